// File: rtl/arm_pkg.sv
// Shared definitions for the fetch side of the pipeline: fetch FSM states and
// architectural constants used when sequencing instruction memory.
package arm_pkg;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] ARM_NOP    = 32'h0;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage : arm_pkg

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns the PC, holds imem in reset while it loads, then
// fetches one word per cycle into the IF/ID register under stall/flush/halt control.
module fetch_sequencer
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          BOOT_CYCLES = 2,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic [31:0]      imem_addr,
  output logic             imem_rst,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic             if_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int             BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0]  BOOT_LAST = BW'(BOOT_CYCLES - 1);

  fetch_state_e  state;
  logic [BW-1:0] boot_cnt;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;

  // Redirect targets are word aligned; the low address bits are dropped on purpose.
  logic unused_branch_lsbs;
  assign unused_branch_lsbs = ^branch_addr[1:0];

  assign pc_plus4  = pc + WORD_BYTES;
  assign imem_addr = pc;
  assign imem_rst  = (state == FS_BOOT);
  assign halted    = (state == FS_HALT);

  // NOTE: every register here is a flop updated with <=, so all branches of the
  // case read the pre-edge values of pc/state regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FS_BOOT;
      boot_cnt    <= '0;
      pc          <= RESET_PC;
      if_pc       <= 32'h0;
      if_instr    <= ARM_NOP;
      if_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        FS_BOOT: begin
          boot_cnt <= boot_cnt + BW'(1);
          if (boot_cnt == BOOT_LAST) state <= FS_RUN;
        end

        FS_RUN: begin
          if (branch_taken) begin
            // Redirect wins over halt and stall; a concurrent halt is dropped.
            pc       <= {branch_addr[31:2], 2'b00};
            if_pc    <= 32'h0;
            if_instr <= ARM_NOP;
            if_valid <= 1'b0;
          end else if (halt_req) begin
            state    <= FS_HALT;
            if_pc    <= 32'h0;
            if_instr <= ARM_NOP;
            if_valid <= 1'b0;
          end else if (!stall) begin
            pc          <= pc_plus4;
            if_pc       <= pc_plus4;
            if_instr    <= imem_instr;
            if_valid    <= 1'b1;
            fetch_count <= fetch_count + CNT_W'(1);
          end
        end

        FS_HALT: begin
          // pc keeps the unfetched address so resume refetches it.
          if (resume_req && !halt_req) state <= FS_RUN;
        end

        default: state <= FS_BOOT;
      endcase
    end
  end

endmodule : fetch_sequencer
